// File: rtl/mem_access_unit.sv
// MEM-stage load/store front-end: aligns MIPS byte/half/word requests onto a
// word-addressed data memory, extends loads, and does read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              misalign,
    output logic              dm_mem_read,
    output logic              dm_mem_write,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_write_data,
    input  logic [DATA_W-1:0] dm_read_data
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] rmw_addr;
    logic [DATA_W-1:0] rmw_data;

    logic              bad;
    logic              accept;
    logic              sub_store;
    logic [ADDR_W-1:0] word_addr;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] merged;

    assign bad       = (req_size == 2'b11)
                    || (req_size == SZ_HALF && req_addr[0])
                    || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
    assign accept    = (state == IDLE) && req_valid && !bad;
    assign sub_store = req_write && (req_size != SZ_WORD);
    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

    // Strobes are suppressed during reset so a reset landing in RMW_WR drops the write.
    assign dm_mem_read   = !reset && accept && (!req_write || sub_store);
    assign dm_mem_write  = !reset && ((accept && req_write && !sub_store) || state == RMW_WR);
    assign stall         = !reset && accept && sub_store;
    assign dm_address    = (state == RMW_WR) ? rmw_addr : word_addr;
    assign dm_write_data = (state == RMW_WR) ? rmw_data : req_wdata;

    // Big-endian lane select and extension of the load result.
    always_comb begin
        byte_sel = 8'h00;
        case (req_addr[1:0])
            2'b00: byte_sel = dm_read_data[31:24];
            2'b01: byte_sel = dm_read_data[23:16];
            2'b10: byte_sel = dm_read_data[15:8];
            2'b11: byte_sel = dm_read_data[7:0];
            default: byte_sel = 8'h00;
        endcase
        half_sel = req_addr[1] ? dm_read_data[15:0] : dm_read_data[31:16];
        case (req_size)
            SZ_BYTE: ext_data = {{24{!req_unsigned && byte_sel[7]}}, byte_sel};
            SZ_HALF: ext_data = {{16{!req_unsigned && half_sel[15]}}, half_sel};
            default: ext_data = dm_read_data;
        endcase
    end

    // Merge the store lane into the word read this cycle.
    always_comb begin
        merged = dm_read_data;
        if (req_size == SZ_BYTE) begin
            case (req_addr[1:0])
                2'b00: merged[31:24] = req_wdata[7:0];
                2'b01: merged[23:16] = req_wdata[7:0];
                2'b10: merged[15:8]  = req_wdata[7:0];
                2'b11: merged[7:0]   = req_wdata[7:0];
                default: merged = dm_read_data;
            endcase
        end else if (req_addr[1]) begin
            merged[15:0] = req_wdata[15:0];
        end else begin
            merged[31:16] = req_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            load_data  <= '0;
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            rmw_addr   <= '0;
            rmw_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    load_valid <= accept && !req_write;
                    misalign   <= req_valid && bad;
                    if (accept && !req_write) begin
                        load_data <= ext_data;
                    end
                    if (accept && sub_store) begin
                        rmw_addr <= word_addr;
                        rmw_data <= merged;
                        state    <= RMW_WR;
                    end
                end
                RMW_WR: begin
                    // The re-presented request is consumed here without a second access.
                    load_valid <= 1'b0;
                    misalign   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random traffic, checked against an
// arithmetic reference of big-endian load/store semantics over a shadow memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic        dm_mem_read;
    logic        dm_mem_write;
    logic [31:0] dm_address;
    logic [31:0] dm_write_data;
    logic [31:0] dm_read_data;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid), .misalign(misalign),
        .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write), .dm_address(dm_address),
        .dm_write_data(dm_write_data), .dm_read_data(dm_read_data)
    );

    // Data memory environment (64 words, addresses 0x00-0xFF).
    logic [31:0] mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (dm_mem_write) mem[dm_address[7:2]] <= dm_write_data;
    end
    assign dm_read_data = mem[dm_address[7:2]];

    // Reference state.
    logic [31:0] ref_mem [64];
    logic [31:0] exp_ld;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [1:0] sz, input logic [31:0] a);
        int unsigned ua = a;
        return (sz == 2'd0) || (sz == 2'd1 && ua % 2 == 0) || (sz == 2'd2 && ua % 4 == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] a);
        int unsigned v;
        int unsigned off = a % 4;
        if (sz == 2'd2) return w;
        if (sz == 2'd0) begin
            v = (w >> (8 * (3 - off))) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else begin
            v = (w >> (16 * (1 - off / 2))) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] d);
        int unsigned off = a % 4;
        int unsigned sh, lane, keep;
        if (sz == 2'd2) return d;
        if (sz == 2'd0) begin
            sh = 8 * (3 - off);
            lane = 256;
        end else begin
            sh = 16 * (1 - off / 2);
            lane = 65536;
        end
        keep = w - (((w >> sh) % lane) << sh);
        return keep + ((d % lane) << sh);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_idx = a[7:2]; pre_data = d;
        @(posedge clk); @(negedge clk);
        pre_we = 1'b0;
        ref_mem[a[7:2]] = d;
    endtask

    // One request presented at a negedge; returns at a negedge with the request retired.
    task automatic do_op(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d);
        bit          ok  = legal(sz, a);
        bit          sub = w && sz != 2'd2;
        logic [31:0] nw;
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = d;
        #1;
        check("stall", stall, 32'(ok && sub));
        check("dm_rd", dm_mem_read, 32'(ok && (!w || sub)));
        check("dm_wr", dm_mem_write, 32'(ok && w && !sub));
        if (ok) check("dm_addr", dm_address, {a[31:2], 2'b00});
        if (ok && w && !sub) check("sw_wdata", dm_write_data, d);
        if (ok && !w) exp_ld = ref_load(ref_mem[a[7:2]], sz, uns, a);
        @(posedge clk); @(negedge clk);
        check("load_valid", load_valid, 32'(ok && !w));
        check("misalign", misalign, 32'(!ok));
        check("load_data", load_data, exp_ld);
        if (ok && w) begin
            if (!sub) begin
                ref_mem[a[7:2]] = d;
            end else begin
                nw = ref_store(ref_mem[a[7:2]], sz, a, d);
                #1;
                check("rmw_stall", stall, 32'd0);
                check("rmw_wr", dm_mem_write, 32'd1);
                check("rmw_rd", dm_mem_read, 32'd0);
                check("rmw_addr", dm_address, {a[31:2], 2'b00});
                check("rmw_wdata", dm_write_data, nw);
                ref_mem[a[7:2]] = nw;
                @(posedge clk); @(negedge clk);
                check("rmw_lvalid", load_valid, 32'd0);
                check("rmw_misal", misalign, 32'd0);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        #1;
        check("idle_rd", dm_mem_read, 32'd0);
        check("idle_wr", dm_mem_write, 32'd0);
        check("idle_stall", stall, 32'd0);
        @(posedge clk); @(negedge clk);
        check("idle_lvalid", load_valid, 32'd0);
        check("idle_misal", misalign, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        exp_ld = 32'h0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);
        #1;
        check("rst_rd", dm_mem_read, 32'd0);
        check("rst_wr", dm_mem_write, 32'd0);
        check("rst_stall", stall, 32'd0);
        check("rst_ldata", load_data, 32'd0);
        check("rst_lvalid", load_valid, 32'd0);
        check("rst_misal", misalign, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;

        // Loads.
        preload(32'h10, 32'h11223344);
        do_op(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
        check("lb_12", load_data, 32'h00000033);
        preload(32'h10, 32'h80223344);
        do_op(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
        check("lb_neg", load_data, 32'hFFFFFF80);
        do_op(1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
        check("lbu", load_data, 32'h00000080);
        preload(32'h10, 32'h11223344);
        do_op(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
        check("lh_10", load_data, 32'h00001122);
        preload(32'h10, 32'hFFEE0000);
        do_op(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
        check("lh_neg", load_data, 32'hFFFFFFEE);
        do_op(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
        check("lhu", load_data, 32'h0000FFEE);
        do_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        check("lh_12", load_data, 32'h00000000);

        // Stores.
        preload(32'h10, 32'h11223344);
        do_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB);
        check("sb_mem", mem[4], 32'h11AB3344);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lw_after_sb", load_data, 32'h11AB3344);
        preload(32'h10, 32'h11223344);
        do_op(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF);
        check("sh_mem", mem[4], 32'h1122BEEF);
        do_op(1'b1, 2'd2, 1'b0, 32'h14, 32'hCAFEF00D);
        check("sw_mem", mem[5], 32'hCAFEF00D);

        // Rejected requests.
        preload(32'h10, 32'h11223344);
        do_op(1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
        do_op(1'b0, 2'd2, 1'b0, 32'h16, 32'h0);
        do_op(1'b1, 2'd3, 1'b0, 32'h10, 32'hDEADBEEF);
        check("rej_mem", mem[4], 32'h11223344);

        // Reset during the RMW write cycle drops the write.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h11; req_wdata = 32'h000000AB;
        #1 check("rstrmw_stall", stall, 32'd1);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstrmw_wr", dm_mem_write, 32'd0);
        check("rstrmw_stall2", stall, 32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        exp_ld = 32'h0;
        check("rstrmw_ldata", load_data, 32'd0);
        check("rstrmw_lvalid", load_valid, 32'd0);
        check("rstrmw_misal", misalign, 32'd0);
        check("rstrmw_mem", mem[4], 32'h11223344);
        do_op(1'b0, 2'd2, 1'b1, 32'h10, 32'h0);
        check("lw_after_rst", load_data, 32'h11223344);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) idle_cycle();
            else do_op(1'($urandom), 2'($urandom), 1'($urandom),
                       32'($urandom_range(0, 255)), $urandom);
        end

        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
